// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scanned seven-segment bus and decoded snapshot outputs
interface seg_scan_decoder_if;
    logic [6:0] seg;
    logic [3:0] AN;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] blank;
    logic       frame_valid;
    logic       active;
    logic       bad_pattern;
    logic       ghost;

    modport master (
        output seg, AN,
        input  digit0, digit1, digit2, digit3, blank,
        input  frame_valid, active, bad_pattern, ghost
    );

    modport slave (
        input  seg, AN,
        output digit0, digit1, digit2, digit3, blank,
        output frame_valid, active, bad_pattern, ghost
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds four hex digits from a multiplexed seg/AN scan
// and publishes them as one snapshot per completed frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65535
) (
    input  logic                clk,
    input  logic                reset,
    seg_scan_decoder_if.slave   bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    logic [6:0]      s_seg_q, p_seg_q;
    logic [3:0]      s_an_q, p_an_q;
    logic [SW-1:0]   stab_q, stab_d;
    logic [TW-1:0]   to_q, to_d;
    logic [3:0][3:0] work_q, work_d, dig_q, dig_d;
    logic [3:0]      wblank_q, wblank_d, blank_q, blank_d;
    logic [3:0]      seen_q, seen_d;
    logic            fv_q, fv_d, act_q, act_d, bad_q, bad_d, ghost_q, ghost_d;

    logic            same, capture, one_hot, multi, accepted;
    logic [3:0]      an_low;
    logic [5:0]      dec;

    // Returns {valid, blank, value}; input is the raw active-low segment drive.
    function automatic logic [5:0] decode(input logic [6:0] seg_n);
        logic [6:0] p;
        p = ~seg_n;
        case (p)
            7'h3F: decode = 6'b10_0000;
            7'h06: decode = 6'b10_0001;
            7'h5B: decode = 6'b10_0010;
            7'h4F: decode = 6'b10_0011;
            7'h66: decode = 6'b10_0100;
            7'h6D: decode = 6'b10_0101;
            7'h7D: decode = 6'b10_0110;
            7'h07: decode = 6'b10_0111;
            7'h7F: decode = 6'b10_1000;
            7'h6F: decode = 6'b10_1001;
            7'h77: decode = 6'b10_1010;
            7'h7C: decode = 6'b10_1011;
            7'h39: decode = 6'b10_1100;
            7'h5E: decode = 6'b10_1101;
            7'h79: decode = 6'b10_1110;
            7'h71: decode = 6'b10_1111;
            7'h00: decode = 6'b11_0000;
            default: decode = 6'b00_0000;
        endcase
    endfunction

    always_comb begin
        same    = ({s_an_q, s_seg_q} == {p_an_q, p_seg_q});
        if (!same)
            stab_d = SW'(1);
        else if (stab_q == STAB_MAX)
            stab_d = stab_q;
        else
            stab_d = stab_q + 1'b1;
        // Fires only on the transition into saturation, so a held pattern captures once.
        capture = (stab_d == STAB_MAX) && (stab_q != STAB_MAX);
        an_low  = ~s_an_q;
        multi   = (an_low & (an_low - 4'd1)) != 4'd0;
        one_hot = (an_low != 4'd0) && !multi;
        dec     = decode(s_seg_q);
    end

    always_comb begin
        work_d   = work_q;
        wblank_d = wblank_q;
        seen_d   = seen_q;
        dig_d    = dig_q;
        blank_d  = blank_q;
        fv_d     = 1'b0;
        act_d    = act_q;
        bad_d    = 1'b0;
        ghost_d  = 1'b0;
        to_d     = to_q;
        accepted = 1'b0;

        if (seen_q == 4'hF) begin
            dig_d   = work_q;
            blank_d = wblank_q;
            fv_d    = 1'b1;
            act_d   = 1'b1;
            seen_d  = 4'h0;
        end

        if (capture && one_hot) begin
            if (dec[5]) begin
                accepted = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (an_low[k]) begin
                        work_d[k]   = dec[4] ? 4'h0 : dec[3:0];
                        wblank_d[k] = dec[4];
                        seen_d[k]   = 1'b1;
                    end
                end
            end else begin
                bad_d = 1'b1;
            end
        end
        if (capture && multi)
            ghost_d = 1'b1;

        // An accepted capture always beats a timeout landing on the same cycle.
        if (accepted) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
            if (to_d == TO_MAX) begin
                seen_d = 4'h0;
                act_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_seg_q  <= '0;
            s_an_q   <= '0;
            p_seg_q  <= '0;
            p_an_q   <= '0;
            stab_q   <= '0;
            to_q     <= '0;
            work_q   <= '0;
            wblank_q <= '0;
            seen_q   <= '0;
            dig_q    <= '0;
            blank_q  <= '0;
            fv_q     <= 1'b0;
            act_q    <= 1'b0;
            bad_q    <= 1'b0;
            ghost_q  <= 1'b0;
        end else begin
            s_seg_q  <= bus.seg;
            s_an_q   <= bus.AN;
            p_seg_q  <= s_seg_q;
            p_an_q   <= s_an_q;
            stab_q   <= stab_d;
            to_q     <= to_d;
            work_q   <= work_d;
            wblank_q <= wblank_d;
            seen_q   <= seen_d;
            dig_q    <= dig_d;
            blank_q  <= blank_d;
            fv_q     <= fv_d;
            act_q    <= act_d;
            bad_q    <= bad_d;
            ghost_q  <= ghost_d;
        end
    end

    assign bus.digit0      = dig_q[0];
    assign bus.digit1      = dig_q[1];
    assign bus.digit2      = dig_q[2];
    assign bus.digit3      = dig_q[3];
    assign bus.blank       = blank_q;
    assign bus.frame_valid = fv_q;
    assign bus.active      = act_q;
    assign bus.bad_pattern = bad_q;
    assign bus.ghost       = ghost_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;
    localparam int STABLE = 4;
    localparam int TMO    = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gfedcba, active-high, for hex 0..F
    logic [6:0] hexpat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [19:0] exp_q [$];
    int cyc = 0;
    int fv_count = 0, bad_count = 0, ghost_count = 0;
    int fv_cyc = 0, fall_cyc = -1;
    logic act_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            act_prev = 1'b0;
        end else begin
            if (bus.frame_valid) begin
                fv_count++;
                fv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("fv_unexpected", 1, 0);
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    check("frame_digits", {16'h0, bus.digit3, bus.digit2, bus.digit1, bus.digit0},
                          {16'h0, e[15:0]});
                    check("frame_blank", {28'h0, bus.blank}, {28'h0, e[19:16]});
                end
            end
            if (bus.bad_pattern) bad_count++;
            if (bus.ghost) ghost_count++;
            if (act_prev && !bus.active) fall_cyc = cyc;
            act_prev = bus.active;
        end
    end

    task automatic show(input int idx, input logic [6:0] pat, input int hold);
        logic [3:0] one;
        one = 4'b0001 << idx;
        bus.AN  = ~one;
        bus.seg = ~pat;
        repeat (hold) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.AN  = 4'hF;
        bus.seg = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    // Negative value means a dark digit.
    task automatic frame(input int v3, input int v2, input int v1, input int v0);
        int v [4];
        logic [19:0] e;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] < 0) e[16+i] = 1'b1;
            else e[4*i +: 4] = v[i][3:0];
        end
        exp_q.push_back(e);
        for (int i = 3; i >= 0; i--)
            show(i, (v[i] < 0) ? 7'h00 : hexpat[v[i]], 8);
        idle(4);
    endtask

    initial begin
        int f0, b0, g0;
        reset   = 1'b0;
        bus.AN  = 4'hF;
        bus.seg = 7'h7F;
        repeat (3) @(negedge clk);
        check("rst_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 0);
        check("rst_blank", bus.blank, 0);
        check("rst_fv", bus.frame_valid, 0);
        check("rst_active", bus.active, 0);
        check("rst_bad", bus.bad_pattern, 0);
        check("rst_ghost", bus.ghost, 0);
        reset = 1'b1;
        idle(5);

        frame(1, 2, 3, 4);
        check("f1_count", fv_count, 1);
        check("f1_active", bus.active, 1);

        frame(-1, 0, 9, 15);
        check("f2_count", fv_count, 2);

        f0 = fv_count; b0 = bad_count; g0 = ghost_count;
        for (int i = 0; i < 10; i++) begin
            show(1, hexpat[5], 2);
            show(0, hexpat[6], 2);
        end
        idle(8);
        check("glitch_fv", fv_count, f0);
        check("glitch_bad", bad_count, b0);
        check("glitch_ghost", ghost_count, g0);

        bus.AN  = 4'b1100;
        bus.seg = ~hexpat[3];
        repeat (6) @(negedge clk);
        idle(8);
        check("ghost_once", ghost_count, g0 + 1);
        check("ghost_no_fv", fv_count, f0);

        fall_cyc = -1;
        exp_q.push_back(20'h07ACD);
        show(3, hexpat[7], 8);
        show(2, hexpat[10], 8);
        show(1, 7'h49, 8);
        show(1, hexpat[12], 8);
        show(0, hexpat[13], 8);
        idle(4);
        check("bad_once", bad_count, b0 + 1);
        check("bad_frame_count", fv_count, f0 + 1);

        idle(80);
        check("timeout_cycle", fall_cyc - fv_cyc, TMO - 1);
        check("timeout_active", bus.active, 0);
        check("timeout_retain", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h7ACD);
        check("timeout_blank", bus.blank, 0);

        f0 = fv_count;
        show(3, hexpat[1], 8);
        show(2, hexpat[2], 8);
        #2 reset = 1'b0;
        #1;
        check("midrst_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 0);
        check("midrst_blank", bus.blank, 0);
        check("midrst_fv", bus.frame_valid, 0);
        check("midrst_active", bus.active, 0);
        @(negedge clk);
        reset = 1'b1;
        show(1, hexpat[3], 8);
        show(0, hexpat[4], 8);
        idle(10);
        check("midrst_no_fv", fv_count, f0);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
